// File: rtl/cpu_test_monitor.sv
// Run monitor for CPU program tests: snoops the data-memory write bus and the PC,
// ends each run in PASS/FAIL (tohost write), HALTED (PC self-loop) or TIMEOUT.
module cpu_test_monitor #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_0FFC,
    parameter logic [31:0] RESULT_BASE    = 32'h0000_0F00,
    parameter int unsigned RESULT_DEPTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 500,
    parameter int unsigned STALL_CYCLES   = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [31:0]                        pc,
    input  logic [31:0]                        memory_address,
    input  logic [DATA_WIDTH-1:0]              memory_write,
    input  logic                               memory_we,
    output logic                               running,
    output logic                               done,
    output logic                               pass,
    output logic                               halted,
    output logic                               timeout,
    output logic [DATA_WIDTH-1:0]              tohost_value,
    output logic [31:0]                        cycle_count,
    output logic [RESULT_DEPTH-1:0]            result_valid,
    output logic [RESULT_DEPTH*DATA_WIDTH-1:0] result_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_HALTED,
        S_TIMEOUT
    } state_t;

    localparam logic [31:0]           RESULT_END   = RESULT_BASE + 32'(4 * RESULT_DEPTH);
    localparam logic [31:0]           TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]           STALL_LAST   = 32'(STALL_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] PASS_CODE    = DATA_WIDTH'(1);

    state_t                            state_q, state_d;
    logic [31:0]                       cycle_count_q, cycle_count_d;
    logic [DATA_WIDTH-1:0]             tohost_value_q, tohost_value_d;
    logic [RESULT_DEPTH-1:0]           result_valid_q, result_valid_d;
    logic [RESULT_DEPTH*DATA_WIDTH-1:0] result_data_q, result_data_d;
    logic [31:0]                       stall_cnt_q, stall_cnt_d;
    logic [31:0]                       pc_prev_q, pc_prev_d;
    logic                              pc_prev_vld_q, pc_prev_vld_d;

    logic        tohost_hit;
    logic        in_window;
    logic        pc_same;
    logic [31:0] win_off;

    assign tohost_hit = memory_we && (memory_address == TOHOST_ADDR);
    assign in_window  = memory_we && (memory_address[1:0] == 2'b00) &&
                        (memory_address >= RESULT_BASE) && (memory_address < RESULT_END);
    assign win_off    = memory_address - RESULT_BASE;
    // pc_prev is meaningless until the first RUN edge has loaded it
    assign pc_same    = pc_prev_vld_q && (pc == pc_prev_q);

    always_comb begin
        state_d        = state_q;
        cycle_count_d  = cycle_count_q;
        tohost_value_d = tohost_value_q;
        result_valid_d = result_valid_q;
        result_data_d  = result_data_q;
        stall_cnt_d    = stall_cnt_q;
        pc_prev_d      = pc_prev_q;
        pc_prev_vld_d  = pc_prev_vld_q;

        if (start) begin
            state_d        = S_RUN;
            cycle_count_d  = '0;
            tohost_value_d = '0;
            result_valid_d = '0;
            result_data_d  = '0;
            stall_cnt_d    = '0;
            pc_prev_d      = '0;
            pc_prev_vld_d  = 1'b0;
        end else if (state_q == S_RUN) begin
            cycle_count_d = cycle_count_q + 32'd1;
            pc_prev_d     = pc;
            pc_prev_vld_d = 1'b1;
            stall_cnt_d   = pc_same ? stall_cnt_q + 32'd1 : 32'd0;

            if (in_window) begin
                for (int unsigned i = 0; i < RESULT_DEPTH; i++) begin
                    if (win_off == (32'(i) << 2)) begin
                        result_valid_d[i]                          = 1'b1;
                        result_data_d[i*DATA_WIDTH +: DATA_WIDTH] = memory_write;
                    end
                end
            end

            // Exit priority: tohost beats halt, halt beats timeout
            if (tohost_hit) begin
                tohost_value_d = memory_write;
                state_d        = (memory_write == PASS_CODE) ? S_PASS : S_FAIL;
            end else if (pc_same && (stall_cnt_q == STALL_LAST)) begin
                state_d = S_HALTED;
            end else if (cycle_count_q == TIMEOUT_LAST) begin
                state_d = S_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cycle_count_q  <= '0;
            tohost_value_q <= '0;
            result_valid_q <= '0;
            result_data_q  <= '0;
            stall_cnt_q    <= '0;
            pc_prev_q      <= '0;
            pc_prev_vld_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cycle_count_q  <= cycle_count_d;
            tohost_value_q <= tohost_value_d;
            result_valid_q <= result_valid_d;
            result_data_q  <= result_data_d;
            stall_cnt_q    <= stall_cnt_d;
            pc_prev_q      <= pc_prev_d;
            pc_prev_vld_q  <= pc_prev_vld_d;
        end
    end

    assign running      = (state_q == S_RUN);
    assign pass         = (state_q == S_PASS);
    assign halted       = (state_q == S_HALTED);
    assign timeout      = (state_q == S_TIMEOUT);
    assign done         = (state_q == S_PASS) || (state_q == S_FAIL) ||
                          (state_q == S_HALTED) || (state_q == S_TIMEOUT);
    assign tohost_value = tohost_value_q;
    assign cycle_count  = cycle_count_q;
    assign result_valid = result_valid_q;
    assign result_data  = result_data_q;

endmodule

// File: tb/tb_cpu_test_monitor.sv
// Scoreboard bench for cpu_test_monitor: each run pushes its expected end-of-run
// record; a monitor pops and compares it when done rises.
module tb_cpu_test_monitor;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         memory_we = 1'b0;
    logic [31:0]  pc = 32'h0;
    logic [31:0]  memory_address = 32'h0;
    logic [31:0]  memory_write = 32'h0;
    logic         running, done, pass, halted, timeout;
    logic [31:0]  tohost_value, cycle_count;
    logic [3:0]   result_valid;
    logic [127:0] result_data;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [4:0]   status;
        logic [31:0]  tohost;
        logic [31:0]  cycles;
        logic [3:0]   rvalid;
        logic [127:0] rdata;
        int           id;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [4:0] ST_PASS = 5'b00110;
    localparam logic [4:0] ST_FAIL = 5'b00010;
    localparam logic [4:0] ST_HALT = 5'b01010;
    localparam logic [4:0] ST_TOUT = 5'b10010;

    always #5 clk = ~clk;

    cpu_test_monitor #(
        .DATA_WIDTH(32),
        .TOHOST_ADDR(32'h0000_0FFC),
        .RESULT_BASE(32'h0000_0F00),
        .RESULT_DEPTH(4),
        .TIMEOUT_CYCLES(500),
        .STALL_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .pc(pc),
        .memory_address(memory_address),
        .memory_write(memory_write),
        .memory_we(memory_we),
        .running(running),
        .done(done),
        .pass(pass),
        .halted(halted),
        .timeout(timeout),
        .tohost_value(tohost_value),
        .cycle_count(cycle_count),
        .result_valid(result_valid),
        .result_data(result_data)
    );

    function automatic logic [4:0] status();
        return {timeout, halted, pass, done, running};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: one scoreboard pop per rising edge of done
    logic done_seen = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        if (done && !done_seen) begin
            done_seen = 1'b1;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 128'(status()), 128'(0));
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("run%0d_status", e.id), 128'(status()), 128'(e.status));
                chk($sformatf("run%0d_tohost", e.id), 128'(tohost_value), 128'(e.tohost));
                chk($sformatf("run%0d_cycles", e.id), 128'(cycle_count), 128'(e.cycles));
                chk($sformatf("run%0d_rvalid", e.id), 128'(result_valid), 128'(e.rvalid));
                chk($sformatf("run%0d_rdata", e.id), result_data, e.rdata);
            end
        end
        if (!done) done_seen = 1'b0;
    end

    task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] data);
        memory_we      = we;
        memory_address = addr;
        memory_write   = data;
        pc             = pc + 32'd4;
        @(negedge clk);
        memory_we = 1'b0;
    endtask

    task automatic step_pc(input logic [31:0] p);
        memory_we = 1'b0;
        pc        = p;
        @(negedge clk);
    endtask

    task automatic do_start();
        start     = 1'b1;
        memory_we = 1'b0;
        pc        = pc + 32'd4;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step(1'b0, 32'h0, 32'h0);
            n++;
        end
        chk("wait_done_bound", 128'(done), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("reset_status", 128'(status()), 128'(0));
        chk("reset_tohost", 128'(tohost_value), 128'(0));
        chk("reset_cycles", 128'(cycle_count), 128'(0));
        chk("reset_rvalid", 128'(result_valid), 128'(0));
        chk("reset_rdata", result_data, 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Writes while IDLE are ignored, tohost included
        step(1'b1, 32'hFFC, 32'd1);
        step(1'b1, 32'hF00, 32'd5);
        chk("idle_status", 128'(status()), 128'(0));
        chk("idle_rvalid", 128'(result_valid), 128'(0));

        // Run 1: three results then pass
        exp_q.push_back('{ST_PASS, 32'd1, 32'd4, 4'b1011, {32'd3, 32'd0, 32'd9, 32'd6}, 1});
        do_start();
        chk("run1_start_running", 128'(running), 128'(1));
        chk("run1_start_cycles", 128'(cycle_count), 128'(0));
        step(1'b1, 32'hF00, 32'd6);
        step(1'b1, 32'hF04, 32'd9);
        step(1'b1, 32'hF0C, 32'd3);
        chk("run1_mid_rvalid", 128'(result_valid), 128'(4'b1011));
        chk("run1_mid_cycles", 128'(cycle_count), 128'(3));
        step(1'b1, 32'hFFC, 32'd1);
        wait_done(4);

        // Run 2: fail code, later writes ignored
        exp_q.push_back('{ST_FAIL, 32'h2A, 32'd1, 4'b0000, 128'(0), 2});
        do_start();
        step(1'b1, 32'hFFC, 32'h2A);
        wait_done(4);
        step(1'b1, 32'hF00, 32'h55);
        step(1'b1, 32'hFFC, 32'd1);
        step(1'b0, 32'h0, 32'h0);
        chk("run2_after_rvalid", 128'(result_valid), 128'(0));
        chk("run2_after_status", 128'(status()), 128'(ST_FAIL));
        chk("run2_after_tohost", 128'(tohost_value), 128'(32'h2A));
        chk("run2_after_cycles", 128'(cycle_count), 128'(1));

        // Run 3: PC stuck at 0x40 after incrementing
        exp_q.push_back('{ST_HALT, 32'd0, 32'd13, 4'b0000, 128'(0), 3});
        do_start();
        step_pc(32'h30);
        step_pc(32'h34);
        step_pc(32'h38);
        step_pc(32'h3C);
        step_pc(32'h40);
        for (int i = 0; i < 7; i++) step_pc(32'h40);
        chk("run3_not_yet_halted", 128'(halted), 128'(0));
        step_pc(32'h40);
        chk("run3_halted", 128'(halted), 128'(1));
        for (int i = 0; i < 3; i++) step_pc(32'h40);
        chk("run3_frozen_cycles", 128'(cycle_count), 128'(13));

        // Run 4: one stall just short of halt, then timeout
        exp_q.push_back('{ST_TOUT, 32'd0, 32'd500, 4'b0000, 128'(0), 4});
        do_start();
        for (int i = 0; i < 8; i++) step_pc(32'h100);
        chk("run4_short_stall", 128'(halted), 128'(0));
        wait_done(600);

        // Run 5: tohost on the 500th edge beats timeout
        exp_q.push_back('{ST_PASS, 32'd1, 32'd500, 4'b0000, 128'(0), 5});
        do_start();
        for (int i = 0; i < 499; i++) step(1'b0, 32'h0, 32'h0);
        chk("run5_running_499", 128'(running), 128'(1));
        step(1'b1, 32'hFFC, 32'd1);
        wait_done(2);

        // Run 6: halt and timeout on the same edge
        exp_q.push_back('{ST_HALT, 32'd0, 32'd500, 4'b0000, 128'(0), 6});
        do_start();
        for (int i = 1; i <= 500; i++)
            step_pc((i <= 492) ? 32'(32'h2000 + 4 * i) : 32'(32'h2000 + 4 * 492));
        wait_done(2);

        // Run 7: capture filtering and overwrite
        exp_q.push_back('{ST_FAIL, 32'd0, 32'd7, 4'b0010, {32'd0, 32'd0, 32'd7, 32'd0}, 7});
        do_start();
        step(1'b1, 32'hF02, 32'h11);
        step(1'b1, 32'hF10, 32'h22);
        step(1'b1, 32'hEFC, 32'h33);
        step(1'b0, 32'hF08, 32'h44);
        chk("run7_filtered", 128'(result_valid), 128'(0));
        step(1'b1, 32'hF04, 32'd5);
        chk("run7_slot1_first", 128'(result_data[63:32]), 128'(5));
        step(1'b1, 32'hF04, 32'd7);
        step(1'b1, 32'hFFC, 32'd0);
        wait_done(2);

        // Run 8: asynchronous reset mid-run, start ignored under reset
        do_start();
        step(1'b1, 32'hF00, 32'hAB);
        step(1'b0, 32'h0, 32'h0);
        chk("run8_pre_rst_cycles", 128'(cycle_count), 128'(2));
        chk("run8_pre_rst_rvalid", 128'(result_valid), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("run8_rst_status", 128'(status()), 128'(0));
        chk("run8_rst_cycles", 128'(cycle_count), 128'(0));
        chk("run8_rst_rvalid", 128'(result_valid), 128'(0));
        chk("run8_rst_rdata", result_data, 128'(0));
        start = 1'b1;
        @(negedge clk);
        chk("run8_start_in_rst", 128'(running), 128'(0));
        start = 1'b0;
        rst   = 1'b0;
        exp_q.push_back('{ST_PASS, 32'd1, 32'd1, 4'b0000, 128'(0), 8});
        do_start();
        chk("run8_restart_running", 128'(running), 128'(1));
        chk("run8_restart_rvalid", 128'(result_valid), 128'(0));
        step(1'b1, 32'hFFC, 32'd1);
        wait_done(2);

        // Run 9: start while running restarts with cleared state
        exp_q.push_back('{ST_PASS, 32'd1, 32'd2, 4'b0010, {32'd0, 32'd0, 32'd2, 32'd0}, 9});
        do_start();
        step(1'b1, 32'hF00, 32'd1);
        step(1'b0, 32'h0, 32'h0);
        do_start();
        chk("run9_restart_cycles", 128'(cycle_count), 128'(0));
        chk("run9_restart_rvalid", 128'(result_valid), 128'(0));
        step(1'b1, 32'hF04, 32'd2);
        step(1'b1, 32'hFFC, 32'd1);
        wait_done(2);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_test_monitor.md
# cpu_test_monitor

Synthesizable run monitor for CPU program tests. It sits beside the `cpu`/`ram` pair and snoops the data-memory write bus and the program counter. Each run is started by a pulse and ends in exactly one of four outcomes:

- pass/fail, decided by a write to a `tohost` address;
- halt, when the PC is stuck in a self-loop;
- timeout, from a cycle watchdog.

While the program runs, the monitor captures up to `RESULT_DEPTH` result words written to a dedicated window. Any program bench, gcd and others alike, can then check end-of-run status and results without hard-coded delays.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of bus data and captured words
- `TOHOST_ADDR`, 32'h0000_0FFC, word address whose write ends the run
- `RESULT_BASE`, 32'h0000_0F00, first word of result window (word-aligned)
- `RESULT_DEPTH`, 4, number of result slots (1..16)
- `TIMEOUT_CYCLES`, 500, maximum RUN cycles (≥2)
- `STALL_CYCLES`, 8, consecutive cycles of unchanged PC that count as halt (≥2)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a new run (sampled on clock edge)
- `pc`  in  32  CPU program counter
- `memory_address`  in  32  data bus address
- `memory_write`  in  DATA_WIDTH  data bus write data
- `memory_we`  in  1  data bus write enable
- `running`  out  1  state is RUN
- `done`  out  1  state is terminal (PASS/FAIL/HALTED/TIMEOUT)
- `pass`  out  1  state is PASS
- `halted`  out  1  state is HALTED
- `timeout`  out  1  state is TIMEOUT
- `tohost_value`  out  DATA_WIDTH  data of the terminating tohost write
- `cycle_count`  out  32  RUN cycles elapsed
- `result_valid`  out  RESULT_DEPTH  per-slot written flag
- `result_data`  out  RESULT_DEPTH*DATA_WIDTH  slot i at bits [i*DATA_WIDTH +: DATA_WIDTH]

## Operation
- States:
  - IDLE → RUN on `start`.
  - RUN → PASS, FAIL, HALTED or TIMEOUT.
  - A terminal state holds until `start` (→ RUN) or `rst`.
  - `start` in RUN restarts the run.
- On `start`, the following are cleared on the same edge that enters RUN: `cycle_count`, `tohost_value`, `result_valid`, `result_data`, the stall counter and `pc_prev`.
- RUN exit conditions, with priority in the listed order on a given edge:
  1. A write with `memory_we`=1 and `memory_address`==`TOHOST_ADDR` latches `memory_write` into `tohost_value`. The state goes to PASS if the value is 1, otherwise to FAIL.
  2. Halt: the stall counter tracks consecutive cycles with `pc`==`pc_prev`. It resets to 0 whenever the PC changes. The state goes to HALTED on the edge where the counter equals `STALL_CYCLES`-1 and `pc`==`pc_prev`.
  3. TIMEOUT: on the edge where `cycle_count`==`TIMEOUT_CYCLES`-1.
- `pc_prev`:
  - registers `pc` every RUN cycle;
  - the first RUN cycle after `start` never counts as a stall (`pc_prev` is invalid until loaded).
- Result capture, in RUN only:
  - Condition: `memory_we`=1, `memory_address[1:0]`==0, and `RESULT_BASE` ≤ `memory_address` < `RESULT_BASE`+4*`RESULT_DEPTH`.
  - Slot = (`memory_address`−`RESULT_BASE`)>>2. The slot stores `memory_write` and its `result_valid` bit is set.
  - A rewrite overwrites the slot.
  - Unaligned or out-of-window writes are ignored.
- Writes in IDLE or terminal states are ignored entirely, including tohost writes.
- `cycle_count` increments by 1 on every RUN edge, including the exiting edge, and freezes in terminal states. 32-bit wrap cannot occur because `TIMEOUT_CYCLES` < 2^32.

## Timing
- Reset values: state IDLE; all outputs 0; `result_data` all zeros.
- Reset asserted mid-run forces IDLE immediately (asynchronously). `start` is ignored while `rst`=1.
- Latencies:
  - `start` at edge k → `running`=1 after edge k, `cycle_count`=0.
  - The tohost write is sampled at edge n → `done`/`pass` and `tohost_value` are visible after edge n.
  - A result write is visible the cycle after its edge.
- Timeout: a run with no other exit sees `done`=`timeout`=1 after the `TIMEOUT_CYCLES`-th RUN edge, with `cycle_count`=`TIMEOUT_CYCLES`.
- Halt: a PC held constant from RUN cycle j onward gives `halted`=1 exactly `STALL_CYCLES` edges after the first repeated sample.
- Simultaneous events: a tohost write on the same edge as stall or timeout expiry → PASS/FAIL wins. Stall and timeout together → HALTED.
- Status outputs are registered state decodes with no combinational path from inputs.

## Test plan
- `start`, 3 writes to 0xF00/0xF04/0xF0C (values 6, 9, 3), then write 1 to 0xFFC → `pass`=1, `result_valid`=4'b1011, slot3=3, `tohost_value`=1.
- `start`, write 0x2A to 0xFFC → `done`=1, `pass`=0, `tohost_value`=0x2A; a later write to 0xF00 leaves `result_valid`=0.
- `start`, `pc` held at 0x40 after incrementing, `STALL_CYCLES`=8 → `halted`=1 eight edges after the first repeat; `cycle_count` frozen afterwards.
- `start`, `pc` always changing, `TIMEOUT_CYCLES`=500 → `timeout`=1, `cycle_count`=500; tohost write of 1 on the 500th edge instead → `pass`=1.
- Unaligned write to 0xF02 and write to 0xF10 (DEPTH 4) → no capture; write to 0xF04 twice (5 then 7) → slot1=7.
- `rst` asserted mid-RUN between clock edges → all outputs 0 immediately; a `start` pulse then restarts with cleared results.
